spi_cfg_controller: RTL and testbench

//  Sequences the byte stream from the SPI slave into the mixer configuration register bank.

---
 rtl/spi_cfg_controller_pkg.sv | 33 +++
 rtl/spi_cfg_controller_bank.sv | 56 +++++
 rtl/spi_cfg_controller.sv | 169 ++++++++++++++++
 tb/tb_spi_cfg_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_controller_pkg.sv
// Shared definitions for the SPI configuration controller: command opcodes,
// FSM state encoding and the mixer register address map.
package spi_cfg_controller_pkg;

    localparam int ADDR_W = 6;

    localparam logic [1:0] OP_WR1     = 2'b00;
    localparam logic [1:0] OP_WRBURST = 2'b01;
    localparam logic [1:0] OP_COMMIT  = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Mixer register address map (first registers of the bank)
    localparam logic [ADDR_W-1:0] REG_MIX_CTRL   = 6'h00;
    localparam logic [ADDR_W-1:0] REG_MIX_ALPHA  = 6'h01;
    localparam logic [ADDR_W-1:0] REG_MIX_BGCOL  = 6'h02;
    localparam logic [ADDR_W-1:0] REG_MIX_LAYERS = 6'h03;

    function automatic logic [1:0] cmd_opcode(input logic [7:0] cmd);
        return cmd[7:6];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/spi_cfg_controller_bank.sv
// Shadow/active configuration register bank. Writes go to the shadow copy;
// a commit copies the whole shadow bank into the active bank in one cycle.
module spi_cfg_bank
    import spi_cfg_controller_pkg::*;
#(
    parameter int                    NUM_REGS     = 16,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [7:0]              i_wr_data,
    input  logic                    i_commit,
    output logic [NUM_REGS*8-1:0]   o_cfg_regs,
    output logic                    o_cfg_updated
);

    logic r_cfg_updated;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] r_shadow;
            logic [7:0] r_active;
            logic       w_hit;

            assign w_hit = i_wr_en && (i_wr_addr == ADDR_W'(gi));

            // The copy samples r_shadow before a same-cycle write lands.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_shadow <= RESET_VALUES[8*gi +: 8];
                    r_active <= RESET_VALUES[8*gi +: 8];
                end else begin
                    if (w_hit)
                        r_shadow <= i_wr_data;
                    if (i_commit)
                        r_active <= r_shadow;
                end
            end

            assign o_cfg_regs[8*gi +: 8] = r_active;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cfg_updated <= 1'b0;
        else
            r_cfg_updated <= i_commit;
    end

    assign o_cfg_updated = r_cfg_updated;

endmodule

// File: rtl/spi_cfg_controller.sv
// Decodes SPI frames (command byte + data bytes) into register writes on the
// shadow bank and commits shadow->active on a vsync rising edge.
module spi_cfg_controller
    import spi_cfg_controller_pkg::*;
#(
    parameter int                    NUM_REGS     = 16,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES = '0,
    parameter bit                    AUTO_COMMIT  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_byte_in,
    input  logic                    i_byte_valid,
    input  logic                    i_spi_ss,
    input  logic                    i_vsync,
    output logic [NUM_REGS*8-1:0]   o_cfg_regs,
    output logic                    o_cfg_updated,
    output logic                    o_commit_pending,
    output logic                    o_busy,
    output logic [7:0]              o_err_count
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic              r_ss_meta;
    logic              r_ss_sync;
    logic              r_ss_q;
    logic              r_vsync_q;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_burst;
    logic              r_commit_pending;
    logic              r_dirty;
    logic [7:0]        r_err_count;

    logic              w_ss_fall;
    logic              w_ss_rise;
    logic              w_vsync_edge;
    logic              w_commit;
    logic              w_in_range;
    state_t            w_state_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_burst_next;
    logic              w_wr_en;
    logic              w_cmd_commit;
    logic              w_err;
    logic              w_pending_set;

    // Synchroniser resets to "selected" so a frame in flight at reset release is skipped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss_meta <= 1'b0;
            r_ss_sync <= 1'b0;
            r_ss_q    <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_ss_meta <= i_spi_ss;
            r_ss_sync <= r_ss_meta;
            r_ss_q    <= r_ss_sync;
            r_vsync_q <= i_vsync;
        end
    end

    assign w_ss_fall    = r_ss_q & ~r_ss_sync;
    assign w_ss_rise    = ~r_ss_q & r_ss_sync;
    assign w_vsync_edge = i_vsync & ~r_vsync_q;
    assign w_commit     = w_vsync_edge & r_commit_pending;
    assign w_in_range   = {1'b0, r_addr} < NUM_REGS_W;

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_burst_next = r_burst;
        w_wr_en      = 1'b0;
        w_cmd_commit = 1'b0;
        w_err        = 1'b0;
        if (w_ss_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall)
                        w_state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (i_byte_valid) begin
                        case (cmd_opcode(i_byte_in))
                            OP_WR1, OP_WRBURST: begin
                                w_addr_next  = cmd_addr(i_byte_in);
                                w_burst_next = (cmd_opcode(i_byte_in) == OP_WRBURST);
                                w_state_next = ST_DATA;
                            end
                            OP_COMMIT: begin
                                w_cmd_commit = 1'b1;
                                w_state_next = ST_DROP;
                            end
                            default: begin
                                w_err        = 1'b1;
                                w_state_next = ST_DROP;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (i_byte_valid) begin
                        if (w_in_range)
                            w_wr_en = 1'b1;
                        else
                            w_err = 1'b1;
                        if (r_burst)
                            w_addr_next = r_addr + 1'b1;
                        else
                            w_state_next = ST_DROP;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    assign w_pending_set = w_cmd_commit | (AUTO_COMMIT && w_ss_rise && r_dirty);

    // A new request in the commit cycle wins, so it waits for the next vsync edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_addr           <= '0;
            r_burst          <= 1'b0;
            r_commit_pending <= 1'b0;
            r_dirty          <= 1'b0;
            r_err_count      <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_burst <= w_burst_next;
            if (w_pending_set)
                r_commit_pending <= 1'b1;
            else if (w_commit)
                r_commit_pending <= 1'b0;
            if (w_wr_en)
                r_dirty <= 1'b1;
            else if (w_commit)
                r_dirty <= 1'b0;
            if (w_err && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

    spi_cfg_bank #(
        .NUM_REGS     (NUM_REGS),
        .RESET_VALUES (RESET_VALUES)
    ) u_bank (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_wr_en       (w_wr_en),
        .i_wr_addr     (r_addr),
        .i_wr_data     (i_byte_in),
        .i_commit      (w_commit),
        .o_cfg_regs    (o_cfg_regs),
        .o_cfg_updated (o_cfg_updated)
    );

    assign o_commit_pending = r_commit_pending;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_err_count      = r_err_count;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Directed bench: DUT A (16 regs, manual commit, non-zero reset values) and
// DUT B (64 regs, auto-commit) share stimulus; sel routes frames to one of them.
module tb_spi_cfg_controller;

    localparam logic [127:0] RV_A = {8'hC3, 112'd0, 8'h5A};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       spi_ss = 1'b1;
    logic       vsync = 1'b0;
    logic       sel = 1'b0;

    logic         bv_a, ss_a, vs_a, bv_b, ss_b, vs_b;
    logic [127:0] cfg_a;
    logic [511:0] cfg_b;
    logic         upd_a, pend_a, busy_a, upd_b, pend_b, busy_b;
    logic [7:0]   err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    assign bv_a = byte_valid & ~sel;
    assign ss_a = sel ? 1'b1 : spi_ss;
    assign vs_a = vsync & ~sel;
    assign bv_b = byte_valid & sel;
    assign ss_b = sel ? spi_ss : 1'b1;
    assign vs_b = vsync & sel;

    always #5 clk = ~clk;

    spi_cfg_controller #(.NUM_REGS(16), .RESET_VALUES(RV_A), .AUTO_COMMIT(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(bv_a),
        .i_spi_ss(ss_a), .i_vsync(vs_a), .o_cfg_regs(cfg_a), .o_cfg_updated(upd_a),
        .o_commit_pending(pend_a), .o_busy(busy_a), .o_err_count(err_a)
    );

    spi_cfg_controller #(.NUM_REGS(64), .RESET_VALUES(512'd0), .AUTO_COMMIT(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(bv_b),
        .i_spi_ss(ss_b), .i_vsync(vs_b), .o_cfg_regs(cfg_b), .o_cfg_updated(upd_b),
        .o_commit_pending(pend_b), .o_busy(busy_b), .o_err_count(err_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %02h", tag, got);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic ss_open();
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_close();
        spi_ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic with_vsync);
        byte_in    = b;
        byte_valid = 1'b1;
        vsync      = with_vsync;
        @(negedge clk);
        byte_valid = 1'b0;
        vsync      = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a_reg0", cfg_a[7:0], 8'h5A);
        chk("rst_a_reg15", cfg_a[127:120], 8'hC3);
        chk("rst_a_busy", 8'(busy_a), 8'h00);
        chk("rst_a_pend", 8'(pend_a), 8'h00);
        chk("rst_a_upd", 8'(upd_a), 8'h00);
        chk("rst_a_err", err_a, 8'h00);
        chk("rst_b_reg0", cfg_b[7:0], 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // WR1 then COMMIT, copy on vsync edge
        ss_open();
        chk("t1_busy", 8'(busy_a), 8'h01);
        send(8'h03, 1'b0);
        send(8'hA5, 1'b0);
        ss_close();
        chk("t1_idle", 8'(busy_a), 8'h00);
        chk("t1_not_active", cfg_a[31:24], 8'h00);
        ss_open(); send(8'h80, 1'b0); ss_close();
        chk("t1_pend", 8'(pend_a), 8'h01);
        vsync_pulse();
        chk("t1_reg3", cfg_a[31:24], 8'hA5);
        chk("t1_upd", 8'(upd_a), 8'h01);
        chk("t1_pend_clr", 8'(pend_a), 8'h00);
        chk("t1_reg0", cfg_a[7:0], 8'h5A);
        @(negedge clk);
        chk("t1_upd_pulse", 8'(upd_a), 8'h00);

        // Errors: out-of-range data and reserved opcode
        ss_open(); send(8'h14, 1'b0); send(8'h55, 1'b0); ss_close();
        ss_open(); send(8'hC0, 1'b0); ss_close();
        chk("t3_err2", err_a, 8'h02);
        ss_open(); send(8'h80, 1'b0); ss_close();
        vsync_pulse();
        chk("t3_reg4", cfg_a[39:32], 8'h00);
        chk("t3_reg3", cfg_a[31:24], 8'hA5);
        chk("t3_err_commit", err_a, 8'h02);
        for (int i = 0; i < 253; i++) begin
            ss_open(); send(8'hC0, 1'b0); ss_close();
        end
        chk("t3_err255", err_a, 8'hFF);
        ss_open(); send(8'hC0, 1'b0); ss_close();
        chk("t3_err_sat", err_a, 8'hFF);

        // COMMIT decoded in the vsync-edge cycle waits for the next edge
        ss_open(); send(8'h03, 1'b0); send(8'h77, 1'b0); ss_close();
        ss_open();
        send(8'h80, 1'b1);
        chk("t4_pend", 8'(pend_a), 8'h01);
        chk("t4_no_copy", cfg_a[31:24], 8'hA5);
        chk("t4_no_upd", 8'(upd_a), 8'h00);
        ss_close();
        vsync_pulse();
        chk("t4_copy", cfg_a[31:24], 8'h77);
        chk("t4_upd", 8'(upd_a), 8'h01);

        // Aborted burst keeps its write; next frame decodes normally
        ss_open(); send(8'h43, 1'b0); send(8'h9C, 1'b0); ss_close();
        chk("t5_idle", 8'(busy_a), 8'h00);
        ss_open(); send(8'h05, 1'b0); send(8'h66, 1'b0); ss_close();
        ss_open(); send(8'h80, 1'b0); ss_close();
        vsync_pulse();
        chk("t5_reg3", cfg_a[31:24], 8'h9C);
        chk("t5_reg4", cfg_a[39:32], 8'h00);
        chk("t5_reg5", cfg_a[47:40], 8'h66);

        // Burst with address wrap on the 64-register instance
        sel = 1'b1;
        @(negedge clk);
        ss_open();
        send(8'h7E, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        ss_close();
        chk("t2_err", err_b, 8'h00);
        chk("t2_autopend", 8'(pend_b), 8'h01);
        vsync_pulse();
        chk("t2_reg62", cfg_b[503:496], 8'h11);
        chk("t2_reg63", cfg_b[511:504], 8'h22);
        chk("t2_reg0", cfg_b[7:0], 8'h33);
        chk("t2_upd", 8'(upd_b), 8'h01);

        // Reset pulse mid-frame
        ss_open();
        send(8'h01, 1'b0);
        rst_n = 1'b0;
        send(8'h99, 1'b0);
        @(negedge clk);
        chk("t6_rst_reg0", cfg_b[7:0], 8'h00);
        chk("t6_rst_busy", 8'(busy_b), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h02, 1'b0);
        send(8'h44, 1'b0);
        chk("t6_ignored_busy", 8'(busy_b), 8'h00);
        ss_close();
        chk("t6_no_pend", 8'(pend_b), 8'h00);
        chk("t6_a_err", err_a, 8'h00);
        chk("t6_a_reg15", cfg_a[127:120], 8'hC3);
        ss_open(); send(8'h0A, 1'b0); send(8'hEE, 1'b0); ss_close();
        chk("t6_autopend", 8'(pend_b), 8'h01);
        vsync_pulse();
        chk("t6_reg10", cfg_b[87:80], 8'hEE);
        chk("t6_reg2", cfg_b[23:16], 8'h00);
        chk("t6_reg1", cfg_b[15:8], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
